id_ex_stage: RTL and testbench

ID/EX pipeline stage for the RV32I core. It registers the decoded operands and the control bits (`mem_read`, `mem_write`, `reg_write`, `jump`, `branch`) produced by the decode/control logic, and presents them to the execute stage one cycle later. It also detects load-use hazards, inserts bubbles, and handles branch/jump flushes and downstream holds, including a flush that arrives while EX is held.

---
 rtl/id_ex_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_stage.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I ID/EX pipeline register with load-use bubbles, flushes and downstream hold.
// A flush seen while EX is held is remembered and turned into a single bubble once the hold lifts.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [6:0]       id_op,
  input  logic [2:0]       id_funct3,
  input  logic [6:0]       id_funct7,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_reg_write,
  input  logic             id_jump,
  input  logic             id_branch,
  input  logic             flush,
  input  logic             ex_stall,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [6:0]       ex_op,
  output logic [2:0]       ex_funct3,
  output logic [6:0]       ex_funct7,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_reg_write,
  output logic             ex_jump,
  output logic             ex_branch,
  output logic             stall_id,
  output logic [CNT_W-1:0] bubble_count
);
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            jump;
    logic            branch;
  } ex_t;
  ex_t              ex_q, ex_d, id_pkt, bub;
  logic             flush_pending_q, flush_pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             use_rs1, use_rs2, load_use, insert_bubble;
  assign id_pkt = '{valid: id_valid, pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                    imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd, op: id_op,
                    funct3: id_funct3, funct7: id_funct7, mem_read: id_mem_read,
                    mem_write: id_mem_write, reg_write: id_reg_write, jump: id_jump,
                    branch: id_branch};
  always_comb begin
    use_rs1 = id_op inside {OP_R, OP_IMM, OP_LOAD, OP_S, OP_B, OP_JALR};
    use_rs2 = id_op inside {OP_R, OP_S, OP_B};
    load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & id_valid &
               ((use_rs1 & (ex_q.rd == id_rs1)) | (use_rs2 & (ex_q.rd == id_rs2)));
    stall_id = ex_stall | (load_use & ~flush & ~flush_pending_q);
    insert_bubble = ~ex_stall & (flush | flush_pending_q | load_use);
    // Bubbles keep stale data fields; only valid and the controls are cleared.
    bub = ex_q;
    bub.valid = 1'b0;
    bub.mem_read = 1'b0;
    bub.mem_write = 1'b0;
    bub.reg_write = 1'b0;
    bub.jump = 1'b0;
    bub.branch = 1'b0;
    ex_d = ex_stall ? ex_q : insert_bubble ? bub : id_pkt;
    flush_pending_d = ex_stall & (flush_pending_q | flush);
    cnt_d = cnt_q + CNT_W'(insert_bubble);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
      flush_pending_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      flush_pending_q <= flush_pending_d;
      cnt_q <= cnt_d;
    end
  end
  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_data  = ex_q.rs1_data;
  assign ex_rs2_data  = ex_q.rs2_data;
  assign ex_imm       = ex_q.imm;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_op        = ex_q.op;
  assign ex_funct3    = ex_q.funct3;
  assign ex_funct7    = ex_q.funct7;
  assign ex_mem_read  = ex_q.mem_read;
  assign ex_mem_write = ex_q.mem_write;
  assign ex_reg_write = ex_q.reg_write;
  assign ex_jump      = ex_q.jump;
  assign ex_branch    = ex_q.branch;
  assign bubble_count = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven vectors with a scoreboard queue for id_ex_stage.
module tb_id_ex_stage;
  localparam logic [6:0] R = 7'h33, I = 7'h13, LD = 7'h03, S = 7'h23, B = 7'h63;
  localparam logic [6:0] JALR = 7'h67, LUI = 7'h37, JAL = 7'h6F;
  localparam logic [4:0] ADDC = 5'b00100, LDC = 5'b10100, STC = 5'b01000;
  localparam logic [4:0] BRC = 5'b00001, JLC = 5'b00110;
  logic clk = 0, rst, id_valid, flush, ex_stall;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [6:0] id_op, id_funct7;
  logic [2:0] id_funct3;
  logic id_mem_read, id_mem_write, id_reg_write, id_jump, id_branch;
  logic ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch, stall_id;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, bubble_count;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [6:0] ex_op, ex_funct7;
  logic [2:0] ex_funct3;
  int checks = 0, errors = 0;
  typedef struct {
    logic rst, valid;
    logic [31:0] pc;
    logic [4:0] rs1, rs2, rd;
    logic [6:0] op;
    logic [4:0] ctl;
    logic flush, stall, e_sid, e_valid;
    logic [31:0] e_pc;
    logic [4:0] e_rd, e_ctl;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  id_ex_stage #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_op(id_op), .id_funct3(id_funct3), .id_funct7(id_funct7), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .id_jump(id_jump),
    .id_branch(id_branch), .flush(flush), .ex_stall(ex_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_op(ex_op), .ex_funct3(ex_funct3),
    .ex_funct7(ex_funct7), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_jump(ex_jump), .ex_branch(ex_branch),
    .stall_id(stall_id), .bubble_count(bubble_count));
  always #5 clk = ~clk;
  task automatic chk(input string name, input int idx, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask
  task automatic add(input logic r, v, input logic [31:0] pc, input logic [4:0] a, b, d,
                     input logic [6:0] op, input logic [4:0] ctl, input logic fl, st, sid, ev,
                     input logic [31:0] epc, input logic [4:0] erd, ectl, input logic [31:0] ecnt);
    vecs.push_back('{r, v, pc, a, b, d, op, ctl, fl, st, sid, ev, epc, erd, ectl, ecnt});
  endtask
  function automatic vec_t find(input logic [31:0] pc);
    for (int i = 0; i < vecs.size(); i++)
      if (vecs[i].valid && vecs[i].pc == pc) return vecs[i];
    return vecs[0];
  endfunction
  task automatic apply(input vec_t v);
    rst = v.rst; id_valid = v.valid; id_pc = v.pc;
    id_rs1_data = v.pc ^ 32'hA5A5_0000; id_rs2_data = v.pc + 32'd1000; id_imm = ~v.pc;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; id_op = v.op;
    id_funct3 = v.pc[4:2]; id_funct7 = v.pc[10:4];
    {id_mem_read, id_mem_write, id_reg_write, id_jump, id_branch} = v.ctl;
    flush = v.flush; ex_stall = v.stall;
  endtask
  initial begin
    vec_t v, e, src;
    // reset with every ID input driven to ones
    @(negedge clk);
    rst = 1; flush = 0; ex_stall = 0; id_valid = 1;
    {id_pc, id_rs1_data, id_rs2_data, id_imm} = '1;
    {id_rs1, id_rs2, id_rd, id_op, id_funct3, id_funct7} = '1;
    {id_mem_read, id_mem_write, id_reg_write, id_jump, id_branch} = '1;
    @(posedge clk); #1;
    chk("reset_valid", -1, 128'(ex_valid), 128'd0);
    chk("reset_ctl", -1, 128'({ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch}), 128'd0);
    chk("reset_cnt", -1, 128'(bubble_count), 128'd0);
    chk("reset_data", -1, 128'({ex_pc, ex_rs1_data, ex_rs2_data, ex_imm}), 128'd0);
    chk("reset_fields", -1, 128'({ex_rs1, ex_rs2, ex_rd, ex_op, ex_funct3, ex_funct7}), 128'd0);
    // pass-through, load-use and negative hazard cases
    add(0,1,'h100,1,2,3,R,ADDC,0,0, 0,1,'h100,3,ADDC,0);
    add(0,1,'h104,1,0,5,LD,LDC,0,0, 0,1,'h104,5,LDC,0);
    add(0,1,'h108,5,1,6,R,ADDC,0,0, 1,0,0,0,0,1);
    add(0,1,'h108,5,1,6,R,ADDC,0,0, 0,1,'h108,6,ADDC,1);
    add(0,1,'h10C,2,0,0,LD,LDC,0,0, 0,1,'h10C,0,LDC,1);
    add(0,1,'h110,0,0,7,R,ADDC,0,0, 0,1,'h110,7,ADDC,1);
    add(0,1,'h114,1,0,5,LD,LDC,0,0, 0,1,'h114,5,LDC,1);
    add(0,1,'h118,5,5,5,LUI,ADDC,0,0, 0,1,'h118,5,ADDC,1);
    add(0,1,'h11C,1,0,5,LD,LDC,0,0, 0,1,'h11C,5,LDC,1);
    add(0,1,'h120,1,5,7,I,ADDC,0,0, 0,1,'h120,7,ADDC,1);
    add(0,1,'h124,1,0,5,LD,LDC,0,0, 0,1,'h124,5,LDC,1);
    add(0,1,'h128,2,5,0,S,STC,0,0, 1,0,0,0,0,2);
    add(0,1,'h128,2,5,0,S,STC,0,0, 0,1,'h128,0,STC,2);
    add(0,1,'h12C,1,0,5,LD,LDC,0,0, 0,1,'h12C,5,LDC,2);
    add(0,0,'h130,5,5,9,R,ADDC,0,0, 0,0,0,0,ADDC,2);
    // flush, and flush coinciding with load-use
    add(0,1,'h134,1,2,0,B,BRC,1,0, 0,0,0,0,0,3);
    add(0,1,'h138,1,0,5,LD,LDC,0,0, 0,1,'h138,5,LDC,3);
    add(0,1,'h13C,5,1,6,R,ADDC,1,0, 0,0,0,0,0,4);
    add(0,1,'h140,1,2,8,R,ADDC,0,0, 0,1,'h140,8,ADDC,4);
    // flush in the middle of a 3-cycle hold
    add(0,1,'h144,0,0,1,JAL,JLC,0,1, 1,1,'h140,8,ADDC,4);
    add(0,1,'h144,0,0,1,JAL,JLC,1,1, 1,1,'h140,8,ADDC,4);
    add(0,1,'h144,0,0,1,JAL,JLC,0,1, 1,1,'h140,8,ADDC,4);
    add(0,1,'h148,0,0,1,JAL,JLC,0,0, 0,0,0,0,0,5);
    add(0,1,'h148,0,0,1,JAL,JLC,0,0, 0,1,'h148,1,JLC,5);
    // two flushes in one hold give one bubble
    add(0,1,'h14C,1,2,0,B,BRC,1,1, 1,1,'h148,1,JLC,5);
    add(0,1,'h14C,1,2,0,B,BRC,1,1, 1,1,'h148,1,JLC,5);
    add(0,1,'h14C,1,2,0,B,BRC,0,0, 0,0,0,0,0,6);
    add(0,1,'h150,1,2,10,R,ADDC,0,0, 0,1,'h150,10,ADDC,6);
    // load-use while held, then JALR rs1 dependency
    add(0,1,'h154,1,0,5,LD,LDC,0,0, 0,1,'h154,5,LDC,6);
    add(0,1,'h158,5,1,6,R,ADDC,0,1, 1,1,'h154,5,LDC,6);
    add(0,1,'h158,5,1,6,R,ADDC,0,0, 1,0,0,0,0,7);
    add(0,1,'h158,5,1,6,R,ADDC,0,0, 0,1,'h158,6,ADDC,7);
    add(0,1,'h15C,1,0,5,LD,LDC,0,0, 0,1,'h15C,5,LDC,7);
    add(0,1,'h160,5,0,1,JALR,JLC,0,0, 1,0,0,0,0,8);
    add(0,1,'h160,5,0,1,JALR,JLC,0,0, 0,1,'h160,1,JLC,8);
    // reset during a hold with a flush pending
    add(0,1,'h200,1,0,5,LD,LDC,0,0, 0,1,'h200,5,LDC,8);
    add(1,1,'h204,5,1,6,R,ADDC,1,1, 1,0,0,0,0,0);
    add(0,1,'h204,5,1,6,R,ADDC,0,0, 0,1,'h204,6,ADDC,0);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      apply(v);
      #1 chk("stall_id", i, 128'(stall_id), 128'(v.e_sid));
      sb.push_back(v);
      @(posedge clk); #1;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty vec %0d: got 0 entries required 1", i);
        continue;
      end
      e = sb.pop_front();
      chk("ex_valid", i, 128'(ex_valid), 128'(e.e_valid));
      chk("ex_ctl", i, 128'({ex_mem_read, ex_mem_write, ex_reg_write, ex_jump, ex_branch}), 128'(e.e_ctl));
      chk("bubble_count", i, 128'(bubble_count), 128'(e.e_cnt));
      if (e.e_valid) begin
        src = find(e.e_pc);
        chk("ex_pc", i, 128'(ex_pc), 128'(e.e_pc));
        chk("ex_rd", i, 128'(ex_rd), 128'(e.e_rd));
        chk("ex_fields", i, 128'({ex_rs1, ex_rs2, ex_op, ex_funct3, ex_funct7}),
            128'({src.rs1, src.rs2, src.op, e.e_pc[4:2], e.e_pc[10:4]}));
        chk("ex_data", i, 128'({ex_rs1_data, ex_rs2_data, ex_imm}),
            128'({e.e_pc ^ 32'hA5A5_0000, e.e_pc + 32'd1000, ~e.e_pc}));
      end
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
